// File: rtl/rgb_px_assembler_pkg.sv
// Shared definitions for the RGB front end and the grayscale core.
//   DEF_MAX_PIXEL_BITS  : packed RGB width (R [23:16], G [15:8], B [7:0])
//   DEF_PIXEL_WIDTH_OUT : grayscale output width
//   DEF_LINE_PIXELS     : default pixels per line
//   px_phase_t          : byte phase within a pixel
package rgb_px_assembler_pkg;

  localparam int unsigned DEF_MAX_PIXEL_BITS  = 24;
  localparam int unsigned DEF_PIXEL_WIDTH_OUT = 8;
  localparam int unsigned DEF_LINE_PIXELS     = 160;

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } px_phase_t;

endpackage

// File: rtl/rgb_px_assembler.sv
// Byte-to-pixel packer: collects R, G, B channel bytes into a 24-bit pixel,
// pulses px_rdy_o for one cycle per pixel, tracks position within a line and
// flags partial pixels discarded by a line sync.
//   clk_i        : clock, rising edge
//   nreset_i     : synchronous active-low reset
//   byte_valid_i : byte_i carries a channel byte this cycle
//   byte_i       : channel byte
//   sync_i       : start of line; realigns phase to R, clears pixel count
//   out_px_rgb_o : last completed pixel, held between pixels
//   px_rdy_o     : one-cycle pulse, new pixel on out_px_rgb_o
//   line_end_o   : one-cycle pulse with px_rdy_o for the last pixel of a line
//   align_err_o  : one-cycle pulse when sync_i dropped a partial pixel
module rgb_px_assembler
  import rgb_px_assembler_pkg::*;
#(
  parameter int unsigned MAX_PIXEL_BITS = DEF_MAX_PIXEL_BITS,
  parameter int unsigned LINE_PIXELS    = DEF_LINE_PIXELS,
  parameter int unsigned CNT_W          = $clog2(LINE_PIXELS)
) (
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      byte_valid_i,
  input  logic [7:0]                byte_i,
  input  logic                      sync_i,
  output logic [MAX_PIXEL_BITS-1:0] out_px_rgb_o,
  output logic                      px_rdy_o,
  output logic                      line_end_o,
  output logic                      align_err_o
);

  px_phase_t        phase_q, phase_d;
  logic [7:0]       r_hold_q, g_hold_q;
  logic [CNT_W-1:0] px_cnt_q, px_cnt_d;

  logic cap_r, cap_g, complete, err_d, cnt_last;

  // State register: phase, holding registers, counter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      phase_q      <= PH_R;
      r_hold_q     <= '0;
      g_hold_q     <= '0;
      px_cnt_q     <= '0;
      out_px_rgb_o <= '0;
      px_rdy_o     <= 1'b0;
      line_end_o   <= 1'b0;
      align_err_o  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      px_cnt_q    <= px_cnt_d;
      px_rdy_o    <= complete;
      line_end_o  <= complete && cnt_last;
      align_err_o <= err_d;
      if (cap_r) r_hold_q <= byte_i;
      if (cap_g) g_hold_q <= byte_i;
      if (complete) out_px_rgb_o <= MAX_PIXEL_BITS'({r_hold_q, g_hold_q, byte_i});
    end
  end

  // Next-state: sync overrides the normal step and behaves as if in PH_R.
  always_comb begin
    phase_d = phase_q;
    if (sync_i) begin
      phase_d = byte_valid_i ? PH_G : PH_R;
    end else if (byte_valid_i) begin
      unique case (phase_q)
        PH_R:    phase_d = PH_G;
        PH_G:    phase_d = PH_B;
        PH_B:    phase_d = PH_R;
        default: phase_d = PH_R;
      endcase
    end
  end

  // Output decode: capture enables, pixel completion, error and counter.
  always_comb begin
    cap_r    = byte_valid_i && (sync_i || phase_q == PH_R);
    cap_g    = byte_valid_i && !sync_i && phase_q == PH_G;
    complete = byte_valid_i && !sync_i && phase_q == PH_B;
    err_d    = sync_i && phase_q != PH_R;
    cnt_last = (px_cnt_q == CNT_W'(LINE_PIXELS - 1));
    px_cnt_d = px_cnt_q;
    if (sync_i) begin
      px_cnt_d = '0;
    end else if (complete) begin
      px_cnt_d = cnt_last ? '0 : px_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rgb_px_assembler.sv
// Testbench for rgb_px_assembler: per-cycle vector table plus a pixel
// scoreboard checked whenever px_rdy_o fires.
module tb_rgb_px_assembler;

  localparam int unsigned LP = 160;

  logic        clk = 1'b0;
  logic        nreset_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        sync_i = 1'b0;
  logic [23:0] out_px_rgb_o;
  logic        px_rdy_o, line_end_o, align_err_o;

  rgb_px_assembler #(
    .MAX_PIXEL_BITS(24),
    .LINE_PIXELS   (LP)
  ) dut (
    .clk_i        (clk),
    .nreset_i     (nreset_i),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .sync_i       (sync_i),
    .out_px_rgb_o (out_px_rgb_o),
    .px_rdy_o     (px_rdy_o),
    .line_end_o   (line_end_o),
    .align_err_o  (align_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n;
    bit          sync;
    bit          valid;
    logic [7:0]  data;
    bit          exp_rdy;
    bit          exp_le;
    bit          exp_err;
    logic [23:0] exp_px;
  } vec_t;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [24:0] sb_q[$];
  logic [23:0] exp_hold = '0;

  function automatic vec_t mk(bit rst_n, bit sync, bit valid, logic [7:0] d,
                              bit rdy, bit le, bit err, logic [23:0] px);
    vec_t t;
    t.rst_n = rst_n; t.sync = sync; t.valid = valid; t.data = d;
    t.exp_rdy = rdy; t.exp_le = le; t.exp_err = err; t.exp_px = px;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus (called at a negedge), then check the
  // registered outputs at the following negedge.
  task automatic apply(input vec_t t);
    nreset_i     = t.rst_n;
    sync_i       = t.sync;
    byte_valid_i = t.valid;
    byte_i       = t.data;
    if (!t.rst_n) begin
      exp_hold = '0;
    end else if (t.exp_rdy) begin
      exp_hold = t.exp_px;
      sb_q.push_back({t.exp_le, t.exp_px});
    end
    @(negedge clk);
    chk("px_rdy",    {31'd0, px_rdy_o},    {31'd0, t.exp_rdy});
    chk("align_err", {31'd0, align_err_o}, {31'd0, t.exp_err});
    chk("line_end",  {31'd0, line_end_o},  {31'd0, t.exp_rdy & t.exp_le});
    chk("px_hold",   {8'd0, out_px_rgb_o}, {8'd0, exp_hold});
  endtask

  task automatic send_px(input logic [23:0] px, input bit le);
    apply(mk(1, 0, 1, px[23:16], 0, 0, 0, '0));
    apply(mk(1, 0, 1, px[15:8],  0, 0, 0, '0));
    apply(mk(1, 0, 1, px[7:0],   1, le, 0, px));
  endtask

  // Scoreboard: every pixel pulse must match the oldest expected pixel.
  always @(negedge clk) begin
    if (px_rdy_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_px", {8'd0, out_px_rgb_o}, 32'hFFFF_FFFF);
      end else begin
        logic [24:0] e;
        e = sb_q.pop_front();
        chk("sb_px", {8'd0, out_px_rgb_o}, {8'd0, e[23:0]});
        chk("sb_line_end", {31'd0, line_end_o}, {31'd0, e[24]});
      end
    end
  end

  vec_t tbl[$];

  initial begin
    //          rst sy va data   rdy le err px
    // Reset dominates a valid byte.
    tbl.push_back(mk(0, 0, 1, 8'hFF, 0, 0, 0, '0));
    tbl.push_back(mk(0, 1, 1, 8'hFF, 0, 0, 0, '0));
    // Back-to-back pixel, pulse lasts one cycle.
    tbl.push_back(mk(1, 0, 1, 8'h12, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 1, 8'h34, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 1, 8'h56, 1, 0, 0, 24'h123456));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, '0));
    // Idle gaps between channels, changing byte_i while idle.
    tbl.push_back(mk(1, 0, 1, 8'h12, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 0, 8'hEE, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 0, 8'hDD, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 1, 8'h34, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 0, 8'hCC, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 0, 8'hBB, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 1, 8'h56, 1, 0, 0, 24'h123456));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, '0));
    // Sync with valid byte during PH_B: partial AA/BB dropped.
    tbl.push_back(mk(1, 0, 1, 8'hAA, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 1, 8'hBB, 0, 0, 0, '0));
    tbl.push_back(mk(1, 1, 1, 8'h01, 0, 0, 1, '0));
    tbl.push_back(mk(1, 0, 1, 8'h02, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 1, 8'h03, 1, 0, 0, 24'h010203));
    // Sync without valid during PH_G.
    tbl.push_back(mk(1, 0, 1, 8'h77, 0, 0, 0, '0));
    tbl.push_back(mk(1, 1, 0, 8'h99, 0, 0, 1, '0));
    tbl.push_back(mk(1, 0, 1, 8'h0A, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 1, 8'h0B, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 1, 8'h0C, 1, 0, 0, 24'h0A0B0C));
    // Sync with valid in PH_R: no error, byte taken as R.
    tbl.push_back(mk(1, 1, 1, 8'hD1, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 1, 8'hD2, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 1, 8'hD3, 1, 0, 0, 24'hD1D2D3));
    // Reset after R and G: everything cleared, no error pulse.
    tbl.push_back(mk(1, 0, 1, 8'h99, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 1, 8'h88, 0, 0, 0, '0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 1, 8'hC1, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 1, 8'hC2, 0, 0, 0, '0));
    tbl.push_back(mk(1, 0, 1, 8'hC3, 1, 0, 0, 24'hC1C2C3));

    @(negedge clk);
    foreach (tbl[i]) apply(tbl[i]);

    // Full line plus one, starting from a sync in PH_R (no error).
    apply(mk(1, 1, 0, 8'h00, 0, 0, 0, '0));
    for (int p = 1; p <= int'(LP) + 1; p++) begin
      logic [7:0] pb;
      pb = 8'(p);
      send_px({pb, ~pb, pb ^ 8'h5A}, p == int'(LP));
    end
    // A few pixels mid-line, then a sync restarts the count.
    for (int p = 0; p < 3; p++) begin
      logic [7:0] pb;
      pb = 8'(p + 200);
      send_px({pb, pb, ~pb}, 1'b0);
    end
    apply(mk(1, 1, 0, 8'h00, 0, 0, 0, '0));
    for (int p = 1; p <= int'(LP); p++) begin
      logic [7:0] pb;
      pb = 8'(p * 3);
      send_px({~pb, pb ^ 8'hA5, pb}, p == int'(LP));
    end
    apply(mk(1, 0, 0, 8'h00, 0, 0, 0, '0));
    apply(mk(1, 0, 0, 8'h00, 0, 0, 0, '0));

    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_px_assembler.md
# rgb_px_assembler

Front-end byte-to-pixel packer feeding the grayscale core. Accepts an 8-bit byte stream (one colour channel per valid byte, R then G then B) from the chip input pins. Assembles each triple into a 24-bit RGB word and presents it with a one-cycle pixel-ready pulse, in exactly the format the grayscale stage consumes. Also tracks position within a line and flags realignment errors on sync.

## Interface

Parameters:
- `MAX_PIXEL_BITS`, 24: packed RGB width; R in [23:16], G in [15:8], B in [7:0].
- `LINE_PIXELS`, 160: pixels per line; must be ≥ 2.
- `CNT_W`, `$clog2(LINE_PIXELS)`: pixel counter width.

Ports:
- `clk_i`, in, 1: single clock; all logic on its rising edge.
- `nreset_i`, in, 1: reset, synchronous, active-low.
- `byte_valid_i`, in, 1: `byte_i` carries a channel byte this cycle.
- `byte_i`, in, 8: channel byte.
- `sync_i`, in, 1: start of line. Forces the byte phase to R and clears the pixel counter.
- `out_px_rgb_o`, out, `MAX_PIXEL_BITS`: last completed pixel; held between pixels.
- `px_rdy_o`, out, 1: one-cycle pulse; `out_px_rgb_o` holds a new pixel.
- `line_end_o`, out, 1: one-cycle pulse coincident with `px_rdy_o` for the last pixel of a line.
- `align_err_o`, out, 1: one-cycle pulse when `sync_i` discards a partial pixel.

## Operation

- Phase FSM with three states: PH_R → PH_G → PH_B → PH_R.
  - The phase advances only on `byte_valid_i`.
  - No other states exist.
- PH_R + valid: capture `byte_i` into the R holding register; go to PH_G.
- PH_G + valid: capture into the G holding register; go to PH_B.
- PH_B + valid: on the same edge,
  - load `out_px_rgb_o` <= {R_hold, G_hold, byte_i};
  - assert `px_rdy_o` next cycle;
  - go to PH_R.
- Idle cycles (`byte_valid_i`=0) between bytes are allowed in any phase. The holding registers keep their values.
- Pixel counter `px_cnt`:
  - Increments on each completed pixel.
  - When `px_cnt`==`LINE_PIXELS`-1 at completion, assert `line_end_o` with `px_rdy_o` and wrap `px_cnt` to 0.
- `sync_i`=1, taking priority over the normal phase step:
  - Phase is treated as PH_R and `px_cnt` <= 0.
  - If the current phase was PH_G or PH_B, the partial pixel is dropped and `align_err_o` pulses next cycle.
  - If `byte_valid_i` is also high, that byte is captured as R and the phase goes to PH_G.
  - Otherwise the phase goes to PH_R.
  - A sync during PH_B with valid high does not complete the old pixel; it restarts the pixel with this byte as R.
  - A sync while already in PH_R gives no error.
- `out_px_rgb_o` changes only on pixel completion. It is never cleared by sync.

## Timing

- Reset (`nreset_i`=0 at a clock edge) sets:
  - `out_px_rgb_o`=0, `px_rdy_o`=0, `line_end_o`=0, `align_err_o`=0;
  - phase=PH_R, `px_cnt`=0, holding registers=0.
- Reset mid-pixel discards the partial pixel silently; there is no `align_err_o`.
- Latency: `px_rdy_o` is high in the cycle after the edge that samples the B byte. The minimum pixel period is 3 cycles (back-to-back valid bytes).
- All outputs are registered; no combinational path from inputs to outputs.
- `px_rdy_o`, `line_end_o` and `align_err_o` are single-cycle pulses and never stretch. Back-to-back pixels give pulses exactly 3 cycles apart.
- No backpressure: the downstream stage accepts a pixel every cycle `px_rdy_o` is high.

## Structure

- Shared `parameters.svh` holds:
  - `MAX_PIXEL_BITS` and `PIXEL_WIDTH_OUT` (already present);
  - new `LINE_PIXELS` default;
  - phase enum typedef `px_phase_t` {PH_R, PH_G, PH_B}.
- Single module; no sub-modules. The phase FSM, holding registers, output register and line counter all sit in one clocked process plus next-state logic.
- Output ports connect directly to the grayscale core's `px_rdy_i` / `in_px_rgb_i`.

## Test plan

- Reset, then bytes 0x12, 0x34, 0x56 on consecutive valid cycles:
  - `out_px_rgb_o`=0x123456 with `px_rdy_o`=1 one cycle after the third byte;
  - `px_rdy_o`=0 the following cycle.
- Same bytes with 2 idle cycles between each: identical output, with `px_rdy_o` 1 cycle after the B byte. Holding registers are unaffected by the gaps.
- Stream `LINE_PIXELS`+1 pixels (160+1 at default):
  - `line_end_o` pulses only on pixel #160, together with `px_rdy_o`;
  - the counter wraps; pixel #161 has `line_end_o`=0.
- Send R=0xAA, G=0xBB, then `sync_i`=1 with valid byte 0x01, then 0x02, 0x03:
  - `align_err_o` pulses once after the sync cycle;
  - next pixel is 0x010203;
  - the 0xAA/0xBB pixel is never emitted.
- `sync_i` alone in PH_R: no `align_err_o`. Then emit pixels and confirm `line_end_o` timing restarts from count 0.
- Assert `nreset_i`=0 after R and G bytes:
  - all outputs are 0 on the next cycle and no error pulses;
  - the next three bytes form a full new pixel.
